// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between PORTS requesters, the arbiter and one UART transmitter.
// The arbiter uses the slave side; the requesters/transmitter model uses the master side.
interface uart_tx_arbiter_if #(
    parameter int PORTS = 4
);
    logic [8*PORTS-1:0] req_data;
    logic [PORTS-1:0]   req_valid;
    logic [PORTS-1:0]   req_last;
    logic [PORTS-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_data_valid;
    logic               tx_data_ready;

    modport slave (
        input  req_data,
        input  req_valid,
        input  req_last,
        output req_ready,
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport master (
        output req_data,
        output req_valid,
        output req_last,
        input  req_ready,
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter in front of a single UART transmitter.
// A granted port keeps the transmitter until its last byte or until it stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus,
    output logic [PORTS-1:0]  o_grant,
    output logic              o_busy,
    output logic              o_timeout_err
);
    localparam int IW = $clog2(PORTS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_last_grant;
    logic [PORTS-1:0] r_grant;
    logic             r_busy;
    logic             r_timeout_err;
    logic [15:0]      r_timer;

    logic [7:0]       w_bytes [PORTS];
    logic [IW-1:0]    w_next;
    logic [IW-1:0]    w_idx;
    logic             w_found;
    logic             w_owner_valid;
    logic             w_owner_last;
    logic             w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            assign w_bytes[gi]      = bus.req_data[8*gi +: 8];
            assign bus.req_ready[gi] = w_xfer & (r_owner == IW'(gi));
        end
    endgenerate

    assign w_owner_valid     = bus.req_valid[r_owner];
    assign w_owner_last      = bus.req_last[r_owner];
    // Valid is qualified by ready so the transmitter never sees a stale byte.
    assign w_xfer            = (r_state == S_XFER) & w_owner_valid & bus.tx_data_ready;
    assign bus.tx_data_valid = w_xfer;
    assign bus.tx_data       = w_bytes[r_owner];

    // Search upward from the port after the previous owner, wrapping.
    always_comb begin
        w_next  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            w_idx = IW'((int'(r_last_grant) + k) % PORTS);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_owner       <= '0;
            r_last_grant  <= IW'(PORTS - 1);
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_XFER;
                        r_owner <= w_next;
                        r_grant <= PORTS'(1) << w_next;
                        r_busy  <= 1'b1;
                        r_timer <= '0;
                    end
                end
                S_XFER: begin
                    if (w_xfer) begin
                        r_timer <= '0;
                        if (w_owner_last) begin
                            r_state      <= S_IDLE;
                            r_last_grant <= r_owner;
                            r_grant      <= '0;
                            r_busy       <= 1'b0;
                        end
                    end else if (w_owner_valid) begin
                        // Owner is waiting on the transmitter, not stalling.
                        r_timer <= '0;
                    end else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_state       <= S_IDLE;
                        r_last_grant  <= r_owner;
                        r_grant       <= '0;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_timer       <= '0;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 ports, TIMEOUT of 16 cycles.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_uart_tx_arbiter;
    localparam int PORTS   = 4;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst_n;
    logic [PORTS-1:0] o_grant;
    logic             o_busy;
    logic             o_timeout_err;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter_if #(.PORTS(PORTS)) bus ();

    uart_tx_arbiter #(
        .PORTS  (PORTS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_timeout_err(o_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[p]       = v;
        bus.req_data[8*p +: 8] = d;
        bus.req_last[p]        = l;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.req_data      = '0;
        bus.tx_data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] pkt_bytes [3] = '{8'h10, 8'h11, 8'h12};

    initial begin
        int n;
        int got;
        int bad;

        // ---- Reset state ----
        do_reset();
        @(negedge clk);
        check_eq("rst_grant", 32'(o_grant), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_terr", 32'(o_timeout_err), 0);
        check_eq("rst_txv", 32'(bus.tx_data_valid), 0);
        check_eq("rst_rdy", 32'(bus.req_ready), 0);
        next_cycle();

        // ---- Ports 0 and 2 each send one byte ----
        set_port(0, 1'b1, 8'h41, 1'b1);
        set_port(2, 1'b1, 8'h42, 1'b1);
        @(negedge clk);
        check_eq("t1_idle_grant", 32'(o_grant), 0);
        next_cycle();
        @(negedge clk);
        check_eq("t1_grant0", 32'(o_grant), 32'b0001);
        check_eq("t1_txv0", 32'(bus.tx_data_valid), 1);
        check_eq("t1_data0", 32'(bus.tx_data), 32'h41);
        check_eq("t1_rdy0", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        set_port(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("t1_gap_grant", 32'(o_grant), 0);
        check_eq("t1_gap_rdy", 32'(bus.req_ready), 0);
        next_cycle();
        @(negedge clk);
        check_eq("t1_grant2", 32'(o_grant), 32'b0100);
        check_eq("t1_data2", 32'(bus.tx_data), 32'h42);
        check_eq("t1_rdy2", 32'(bus.req_ready), 32'b0100);
        next_cycle();
        set_port(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("t1_end_busy", 32'(o_busy), 0);
        check_eq("t1_end_rdy", 32'(bus.req_ready), 0);
        next_cycle();

        // ---- Rotation with all ports requesting, ready 1 cycle in 3 ----
        do_reset();
        for (int i = 0; i < PORTS; i++) set_port(i, 1'b1, 8'h50 + 8'(i), 1'b1);
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            bus.tx_data_ready = (c % 3 == 0);
            @(negedge clk);
            if (bus.req_ready != '0) begin
                got = -1;
                for (int i = 0; i < PORTS; i++) if (bus.req_ready[i]) got = i;
                check_eq("rr_order", 32'(got), 32'(exp_order[n]));
                check_eq("rr_data", 32'(bus.tx_data), 32'h50 + 32'(exp_order[n]));
                check_eq("rr_onehot", 32'(bus.req_ready), 32'(o_grant));
                n++;
            end
            next_cycle();
        end
        check_eq("rr_count", 32'(n), 6);
        bus.req_valid     = '0;
        bus.tx_data_ready = 1'b1;
        next_cycle();

        // ---- Port 1 multi-byte packet while port 3 waits ----
        do_reset();
        set_port(1, 1'b1, pkt_bytes[0], 1'b0);
        set_port(3, 1'b1, 8'h33, 1'b1);
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            set_port(1, 1'b1, pkt_bytes[b], b == 2);
            @(negedge clk);
            check_eq("mb_data", 32'(bus.tx_data), 32'(pkt_bytes[b]));
            check_eq("mb_rdy", 32'(bus.req_ready), 32'b0010);
            check_eq("mb_grant", 32'(o_grant), 32'b0010);
            next_cycle();
        end
        set_port(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("mb_gap_grant", 32'(o_grant), 0);
        next_cycle();
        @(negedge clk);
        check_eq("mb_grant3", 32'(o_grant), 32'b1000);
        check_eq("mb_data3", 32'(bus.tx_data), 32'h33);
        check_eq("mb_rdy3", 32'(bus.req_ready), 32'b1000);
        next_cycle();
        set_port(3, 1'b0, 8'h00, 1'b0);
        next_cycle();

        // ---- Port 2 stalls mid-packet until timeout, port 3 follows ----
        do_reset();
        set_port(2, 1'b1, 8'h20, 1'b0);
        set_port(3, 1'b1, 8'h33, 1'b1);
        next_cycle();
        @(negedge clk);
        check_eq("to_first_data", 32'(bus.tx_data), 32'h20);
        check_eq("to_first_rdy", 32'(bus.req_ready), 32'b0100);
        next_cycle();
        set_port(2, 1'b0, 8'h00, 1'b0);
        bad = 0;
        for (int s = 0; s < TIMEOUT; s++) begin
            @(negedge clk);
            if (o_grant != 4'b0100 || o_timeout_err || bus.req_ready != '0 || bus.tx_data_valid) bad++;
            next_cycle();
        end
        check_eq("to_stall_ok", 32'(bad), 0);
        @(negedge clk);
        check_eq("to_released", 32'(o_grant), 0);
        check_eq("to_err", 32'(o_timeout_err), 1);
        next_cycle();
        @(negedge clk);
        check_eq("to_err_once", 32'(o_timeout_err), 0);
        check_eq("to_grant3", 32'(o_grant), 32'b1000);
        check_eq("to_rdy3", 32'(bus.req_ready), 32'b1000);
        next_cycle();
        set_port(3, 1'b0, 8'h00, 1'b0);
        next_cycle();

        // ---- Transmitter busy for 100 cycles ----
        bus.tx_data_ready = 1'b0;
        set_port(0, 1'b1, 8'h77, 1'b1);
        next_cycle();
        bad = 0;
        for (int s = 0; s < 100; s++) begin
            @(negedge clk);
            if (o_grant != 4'b0001 || o_timeout_err || bus.req_ready != '0 || bus.tx_data_valid) bad++;
            next_cycle();
        end
        check_eq("bz_hold_ok", 32'(bad), 0);
        bus.tx_data_ready = 1'b1;
        @(negedge clk);
        check_eq("bz_txv", 32'(bus.tx_data_valid), 1);
        check_eq("bz_data", 32'(bus.tx_data), 32'h77);
        check_eq("bz_rdy", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        set_port(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("bz_done_busy", 32'(o_busy), 0);
        next_cycle();

        // ---- Asynchronous reset mid-packet ----
        set_port(2, 1'b1, 8'h2A, 1'b0);
        next_cycle();
        @(negedge clk);
        check_eq("ar_pre_grant", 32'(o_grant), 32'b0100);
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_grant", 32'(o_grant), 0);
        check_eq("ar_busy", 32'(o_busy), 0);
        check_eq("ar_rdy", 32'(bus.req_ready), 0);
        check_eq("ar_txv", 32'(bus.tx_data_valid), 0);
        set_port(0, 1'b1, 8'h01, 1'b1);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("ar_grant0", 32'(o_grant), 32'b0001);
        check_eq("ar_data0", 32'(bus.tx_data), 32'h01);
        next_cycle();
        bus.req_valid = '0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that lets up to PORTS independent requesters share one UART transmitter. It sits between the requesters and the transmitter's byte interface (tx_data / tx_data_valid / tx_data_ready). It grants one requester at a time and holds the grant for a whole packet, delimited by a last flag. A requester that stalls mid-packet beyond a timeout is forcibly released.

## Interface
- PORTS, 4: number of requesters (2..8).
- TIMEOUT, 1024: maximum number of consecutive cycles a granted requester may hold req_valid low mid-packet (1..65535).

Ports:
- clk  in  1  system clock; the block uses this single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_data  in  8*PORTS  byte from each port; port i occupies bits [8i+7:8i].
- req_valid  in  PORTS  port i has a byte on req_data.
- req_last  in  PORTS  the byte on port i is the final byte of its packet.
- req_ready  out  PORTS  one-cycle pulse: the byte on port i was accepted this cycle.
- tx_data  out  8  byte to the transmitter.
- tx_data_valid  out  1  byte to the transmitter is valid.
- tx_data_ready  in  1  transmitter is idle and can accept a byte.
- grant  out  PORTS  one-hot owner of the transmitter; all zero when idle.
- busy  out  1  a grant is held.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM has two states:
  - S_IDLE: grant=0, busy=0.
  - S_XFER: grant holds the owner, busy=1.
- S_IDLE -> S_XFER:
  - Taken on any cycle where req_valid != 0.
  - Owner is the first asserted req_valid searching upward from last_grant+1, wrapping modulo PORTS.
  - The grant register is loaded on that edge.
- Transfer cycle:
  - Condition: state==S_XFER and req_valid[g] and tx_data_ready.
  - Combinational outputs: tx_data_valid = req_valid[g] & tx_data_ready & (state==S_XFER); tx_data = req_data[g]; req_ready[g] = tx_data_valid.
  - tx_data_valid is therefore asserted only while tx_data_ready is high. It is never held across a deasserted ready, so the transmitter never sees a stale valid when it returns to idle.
- On a transfer with req_last[g]=1:
  - Go to S_IDLE.
  - last_grant <= g.
  - Grant is cleared on the same edge.
- Stall timer (16-bit):
  - Cleared on entry to S_XFER, on every transfer, and on every cycle req_valid[g]=1.
  - Increments on each S_XFER cycle with req_valid[g]=0.
  - When it equals TIMEOUT-1 with req_valid[g] still 0: go to S_IDLE, last_grant <= g, timeout_err=1 for the next cycle only.
- Cycles with tx_data_ready=0 (transmitter busy) do not advance the timer while req_valid[g]=1.
- Non-granted ports: req_ready stays 0 and their valid is ignored until arbitration.
- A requester may deassert req_valid between bytes of a packet without losing the grant, provided it stays under the timeout.

## Timing
- Reset values:
  - state S_IDLE; grant 0; busy 0; timeout_err 0.
  - last_grant = PORTS-1, so port 0 has first priority.
  - tx_data_valid 0; req_ready 0; tx_data = req_data[0] (don't-care).
- Arbitration latency:
  - req_valid rising in S_IDLE at edge t gives grant visible after edge t+1.
  - First tx_data_valid occurs in that same cycle if tx_data_ready=1.
- Back-to-back packets: after a last-byte transfer there is one S_IDLE cycle before the next grant. This is hidden by the transmitter's frame time.
- Simultaneous events:
  - A transfer and a timer expiry in the same cycle cannot occur, because expiry requires req_valid[g]=0.
  - A new request arriving during S_XFER waits; it never preempts the owner.
- Reset asserted mid-packet: all state clears asynchronously. The transmitter is reset with the same rst_n.
- Rotation is exact: with all ports continuously requesting single-byte packets, grants go 0,1,2,3,0,...

## Test plan
- Reset, then ports 0 and 2 each request a 1-byte packet (0x41, 0x42, last=1) -> tx sees 0x41 then 0x42; each req_ready pulses exactly one cycle; grant goes 0001, 0000, 0100.
- All 4 ports request continuously with 1-byte packets and tx_data_ready toggling at the frame rate -> grant order 0,1,2,3,0,1; no port granted twice before the others are served.
- Port 1 sends a 3-byte packet 0x10,0x11,0x12 (last on 0x12) while port 3 requests -> port 3 gets no req_ready until 0x12 is accepted; its byte follows.
- Port 2 is granted, sends 1 byte (last=0), then drops valid for TIMEOUT=16 cycles -> release after 16 stalled cycles; timeout_err pulses once; port 3 is granted next.
- tx_data_ready held low for 100 cycles while port 0 holds valid -> tx_data_valid stays 0, no timeout, no req_ready; the byte is accepted on the first ready-high cycle.
- rst_n pulsed low mid-packet -> grant, busy, req_ready and tx_data_valid are 0 immediately; the next arbitration starts at port 0.
